// File: rtl/reward_tx_queue.sv
// reward_tx_queue: decodes received packets and membership timeouts into
// response entries, queued and released one per okToSend grant.
module reward_tx_queue #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TX_LEVELS  = 4,
    parameter int unsigned TS_WIDTH   = 6,
    parameter int unsigned MAX_RIPPLE = 3,
    parameter logic [TX_LEVELS*WORD_WIDTH-1:0] TX_COST =
        {16'h001b, 16'h0011, 16'h0009, 16'h0005}
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           en,
    input  logic                           mr_trigger,
    input  logic                           okToSend,
    input  logic                           iAmDestination,
    input  logic [WORD_WIDTH-1:0]          myEnergy,
    input  logic [WORD_WIDTH-1:0]          myNodeID,
    input  logic [WORD_WIDTH-1:0]          hopsFromSink,
    input  logic [WORD_WIDTH-1:0]          myQValue,
    input  logic                           role,
    input  logic                           low_E,
    input  logic [WORD_WIDTH-1:0]          timeslot,
    input  logic [2:0]                     fPacketType,
    input  logic [WORD_WIDTH-1:0]          fSourceID,
    input  logic [WORD_WIDTH-1:0]          fSourceHops,
    input  logic [WORD_WIDTH-1:0]          chosenCH,
    input  logic [WORD_WIDTH-1:0]          hopsFromCH,
    output logic [WORD_WIDTH-1:0]          rSourceID,
    output logic [WORD_WIDTH-1:0]          rEnergyLeft,
    output logic [WORD_WIDTH-1:0]          rQValue,
    output logic [WORD_WIDTH-1:0]          rSourceHops,
    output logic [WORD_WIDTH-1:0]          rDestinationID,
    output logic [WORD_WIDTH-1:0]          rChosenCH,
    output logic [WORD_WIDTH-1:0]          rHopsFromCH,
    output logic [2:0]                     rPacketType,
    output logic [TS_WIDTH-1:0]            rTimeslot,
    output logic [$clog2(TX_LEVELS+1)-1:0] tx_setting,
    output logic                           tx_valid,
    output logic                           reward_done,
    output logic [$clog2(DEPTH+1)-1:0]     q_count,
    output logic [7:0]                     drop_count
);

    localparam int unsigned LW = $clog2(TX_LEVELS + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [WORD_WIDTH-1:0] TXL_W  = WORD_WIDTH'(TX_LEVELS);
    localparam logic [WORD_WIDTH:0]   RIPPLE = (WORD_WIDTH+1)'(MAX_RIPPLE);
    localparam logic [CW-1:0]         FULL   = CW'(DEPTH);

    typedef struct packed {
        logic [2:0]            ptype;
        logic [WORD_WIDTH-1:0] src;
        logic [WORD_WIDTH-1:0] energy;
        logic [WORD_WIDTH-1:0] qv;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] dest;
        logic [WORD_WIDTH-1:0] ch;
        logic [WORD_WIDTH-1:0] hch;
        logic [TS_WIDTH-1:0]   ts;
        logic [LW-1:0]         lvl;
    } entry_t;

    typedef enum logic [1:0] {IDLE, CAPTURE, DECODE} state_t;

    function automatic logic [LW-1:0] hop_level(
        input logic [WORD_WIDTH-1:0] h
    );
        if (h == '0) return LW'(1);
        if (h > TXL_W) return LW'(TX_LEVELS);
        return h[LW-1:0];
    endfunction

    function automatic logic [WORD_WIDTH-1:0] residual(
        input logic [WORD_WIDTH-1:0] e,
        input logic [LW-1:0]         lvl
    );
        logic [WORD_WIDTH-1:0] cost;
        cost = '0;
        for (int k = 0; k < int'(TX_LEVELS); k++)
            if (lvl == LW'(k + 1))
                cost = TX_COST[k*WORD_WIDTH +: WORD_WIDTH];
        return (e > cost) ? e - cost : '0;
    endfunction

    state_t                state_q;
    logic [2:0]            cap_type_q;
    logic [WORD_WIDTH-1:0] cap_src_q;
    logic [WORD_WIDTH-1:0] cap_hops_q;
    logic                  cap_dest_q;
    logic                  done_q;
    logic                  mr_pend_q;
    logic [TS_WIDTH-1:0]   slot_q;

    entry_t                mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [7:0]            drop_q;
    entry_t                out_q;
    logic                  tx_valid_q;

    logic   push;
    logic   grant;
    logic   svc_mr;
    entry_t ent;
    logic   do_pop;
    logic   full;
    logic   wr;
    logic   drop;
    logic   unused_ts;

    assign unused_ts = ^timeslot;

    always_comb begin
        push   = 1'b0;
        grant  = 1'b0;
        ent    = '0;
        svc_mr = (state_q == IDLE) && !en && mr_pend_q;
        if (state_q == DECODE) begin
            case (cap_type_q)
                3'b000: if (!low_E) begin
                    push      = 1'b1;
                    ent.ptype = 3'b000;
                    ent.dest  = '1;
                    ent.lvl   = LW'(TX_LEVELS);
                end
                3'b010: if (!role && !low_E &&
                            ({1'b0, cap_hops_q} + (WORD_WIDTH+1)'(1)
                             <= RIPPLE)) begin
                    push      = 1'b1;
                    ent.ptype = 3'b010;
                    ent.dest  = '1;
                    ent.ch    = cap_src_q;
                    ent.hch   = cap_hops_q + WORD_WIDTH'(1);
                    ent.lvl   = LW'(1);
                end
                3'b011: if (cap_dest_q && role) begin
                    push      = 1'b1;
                    grant     = 1'b1;
                    ent.ptype = 3'b101;
                    ent.dest  = cap_src_q;
                    ent.ts    = slot_q;
                    ent.lvl   = hop_level(cap_hops_q);
                end
                default: ;
            endcase
        end else if (svc_mr) begin
            push      = 1'b1;
            ent.ptype = 3'b011;
            ent.dest  = chosenCH;
            ent.ch    = chosenCH;
            ent.hch   = hopsFromCH;
            ent.ts    = timeslot[TS_WIDTH-1:0];
            ent.lvl   = hop_level(hopsFromCH);
        end
        if (push) begin
            ent.src    = myNodeID;
            ent.hops   = hopsFromSink;
            ent.qv     = myQValue;
            ent.energy = residual(myEnergy, ent.lvl);
        end
    end

    // A pop frees the head slot on the same edge, so a full queue still
    // accepts a simultaneous push.
    assign do_pop = okToSend && (count_q != '0);
    assign full   = (count_q == FULL);
    assign wr     = push && (!full || do_pop);
    assign drop   = push && full && !do_pop;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            cap_type_q <= '0;
            cap_src_q  <= '0;
            cap_hops_q <= '0;
            cap_dest_q <= 1'b0;
            done_q     <= 1'b0;
            mr_pend_q  <= 1'b0;
            slot_q     <= '0;
        end else begin
            done_q    <= (state_q == CAPTURE);
            mr_pend_q <= mr_trigger | (mr_pend_q & ~svc_mr);
            if (grant) slot_q <= slot_q + TS_WIDTH'(1);
            case (state_q)
                IDLE: if (en) begin
                    cap_type_q <= fPacketType;
                    cap_src_q  <= fSourceID;
                    cap_hops_q <= fSourceHops;
                    cap_dest_q <= iAmDestination;
                    state_q    <= CAPTURE;
                end
                CAPTURE: state_q <= DECODE;
                DECODE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            out_q      <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_valid_q <= do_pop;
            if (do_pop) begin
                out_q    <= mem[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (wr) wr_ptr_q <= wr_ptr_q + PW'(1);
            case ({wr, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
            if (drop && drop_q != 8'hff) drop_q <= drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= ent;
    end

    assign rSourceID      = out_q.src;
    assign rEnergyLeft    = out_q.energy;
    assign rQValue        = out_q.qv;
    assign rSourceHops    = out_q.hops;
    assign rDestinationID = out_q.dest;
    assign rChosenCH      = out_q.ch;
    assign rHopsFromCH    = out_q.hch;
    assign rPacketType    = out_q.ptype;
    assign rTimeslot      = out_q.ts;
    assign tx_setting     = out_q.lvl;
    assign tx_valid       = tx_valid_q;
    assign reward_done    = done_q;
    assign q_count        = count_q;
    assign drop_count     = drop_q;

endmodule

// File: doc/reward_tx_queue.md
Name: reward_tx_queue

Overview:
Parametrised successor to the reward stage of the clustering node. It decodes each received packet (plus a membership-request timeout) into zero or one response packet, and queues responses in a DEPTH-entry FIFO. It releases one response per okToSend grant with a per-hop TX power setting and a projected residual energy. It sits between packetFilter/neighbour logic and the TX framer, and adds CH timeslot granting and queued back-pressure.

Parameters:
WORD_WIDTH, 16, width of IDs, hops, Q-values and energy
DEPTH, 4, response FIFO entries (power of 2, ≥2)
TX_LEVELS, 4, number of hop TX power levels
TS_WIDTH, 6, timeslot field width
MAX_RIPPLE, 3, maximum hop count to which an invitation is re-broadcast
TX_COST, {16'h001b,16'h0011,16'h0009,16'h0005}, packed TX_LEVELS×WORD_WIDTH energy cost; level k at slice k-1

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
en  in  1  one-cycle strobe: packet fields valid
mr_trigger  in  1  one-cycle membership-request timeout
okToSend  in  1  TX grant; pops one entry per high cycle
iAmDestination  in  1  packet addressed to this node
myEnergy, myNodeID, hopsFromSink, myQValue  in  WORD_WIDTH each  node info
role  in  1  1 = cluster head
low_E  in  1  low-energy flag
timeslot  in  WORD_WIDTH  own assigned slot
fPacketType  in  3  received type
fSourceID, fSourceHops  in  WORD_WIDTH each  received fields
chosenCH, hopsFromCH  in  WORD_WIDTH each  KCH result
rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH  out  WORD_WIDTH each  response fields
rPacketType  out  3  response type
rTimeslot  out  TS_WIDTH  response slot
tx_setting  out  $clog2(TX_LEVELS+1)  power level 1..TX_LEVELS
tx_valid  out  1  one-cycle pulse: r* outputs carry a new packet
reward_done  out  1  one-cycle pulse per decoded en
q_count  out  $clog2(DEPTH+1)  FIFO occupancy
drop_count  out  8  saturating count of responses lost to full FIFO

Behaviour:
- Reset: all outputs 0, FIFO empty, slot counter 0, mr pending 0, FSM IDLE. Reset mid-operation discards the queue and any in-flight decode.
- Decode FSM: IDLE → CAPTURE on en (fields registered) → DECODE (push decision) → IDLE. en is ignored outside IDLE. reward_done pulses in the DECODE cycle (2 cycles after en).
- mr_trigger sets the pending flag. The flag is serviced by a push in any IDLE cycle without en, so en wins on collision. The pending flag then clears.
- Decode rules (e = rEnergyLeft = myEnergy − TX_COST[level], saturating at 0; base fields rSourceID=myNodeID, rSourceHops=hopsFromSink, rQValue=myQValue):
  - 000 heartbeat, low_E=0: push type 000, dest all-ones, level TX_LEVELS.
  - 010 invitation, role=0, low_E=0, fSourceHops+1 ≤ MAX_RIPPLE: push type 010, dest all-ones, rChosenCH=fSourceID, rHopsFromCH=fSourceHops+1, level 1.
  - 011 membership request, iAmDestination=1, role=1: push type 101 slot grant, dest=fSourceID, rTimeslot=slot counter, level min(fSourceHops,TX_LEVELS) with 0 treated as 1. The slot counter increments and wraps from 2^TS_WIDTH−1 to 0.
  - mr pending: push type 011, dest=chosenCH, rChosenCH=chosenCH, rHopsFromCH=hopsFromCH, rTimeslot=timeslot[TS_WIDTH-1:0], level min(hopsFromCH,TX_LEVELS), hopsFromCH 0 treated as 1.
  - Any other type or failed condition: no push, reward_done still pulses.
  - Unused fields in a pushed entry are 0.
- Energy is computed at push time from the current myEnergy.
- FIFO: a push when full is dropped and drop_count increments, saturating at 255. A push and a pop in the same cycle are both performed, even when full. A pop when empty is a no-op.
- TX: on an okToSend cycle with q_count>0, the head is registered onto r*/tx_setting next cycle with a tx_valid pulse. Outputs hold until the next pop. Back-to-back grants pop one entry per cycle.
- Wrap: FIFO pointers wrap modulo DEPTH.

Test Plan:
- Reset with myEnergy=0x8000 → all outputs 0, q_count 0; release nrst, idle 5 cycles → no tx_valid.
- Heartbeat: myEnergy=0x7FFC, hopsFromSink=3, myQValue=0x3555, en pulse → reward_done at +2, q_count 1. okToSend → rPacketType 000, rEnergyLeft 0x7FE1, tx_setting 4, rDestinationID 0xFFFF.
- Invitation: fSourceID 23, fSourceHops 1, role 0 → rChosenCH 23, rHopsFromCH 2, tx_setting 1, rEnergyLeft 0x7FF7. Repeat with fSourceHops 3 → no push.
- en and mr_trigger in the same cycle, chosenCH 23, hopsFromCH 1 → invitation entry first, then type 011 to dest 23, tx_setting 1, rTimeslot from timeslot.
- CH role: 65 membership requests with iAmDestination=1, draining each → slot grants 0..63 then 0 (wrap).
- Fill DEPTH+2 heartbeats without okToSend → q_count 4, drop_count 2. Push plus pop while full → q_count stays 4. low_E=1 heartbeat → no push.
